// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake head controller.
// Holds the state and direction enums, the grid defaults and the index helper.
package snake_pkg;

   localparam int GRID_W_DEF = 15;
   localparam int GRID_H_DEF = 15;
   localparam logic [7:0] CENTER_IDX = 8'd112;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SPAWN,
      S_RUN,
      S_CHECK,
      S_COMMIT,
      S_DEAD
   } state_t;

   typedef enum logic [1:0] {
      DIR_UP,
      DIR_DOWN,
      DIR_LEFT,
      DIR_RIGHT
   } dir_t;

   // Row-major cell index; stays below 225, so 8 bits never overflow.
   function automatic logic [7:0] cell_idx(
      input logic [7:0] x,
      input logic [7:0] y,
      input logic [7:0] w
   );
      return (y * w) + x;
   endfunction

   function automatic dir_t dir_opposite(input dir_t d);
      dir_t r;
      unique case (d)
         DIR_UP:    r = DIR_DOWN;
         DIR_DOWN:  r = DIR_UP;
         DIR_LEFT:  r = DIR_RIGHT;
         DIR_RIGHT: r = DIR_LEFT;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/snake_next_pos.sv
// Combinational next-head calculator: one step from (x,y) in dir.
// Ports: x, y, dir in; nx, ny, wall_hit out. SNAKE_WRAP_WALLS_EN wraps edges.
module snake_next_pos
   import snake_pkg::*;
#(
   parameter int GRID_W = GRID_W_DEF,
   parameter int GRID_H = GRID_H_DEF
) (
   input  logic [7:0] x,
   input  logic [7:0] y,
   input  dir_t       dir,
   output logic [7:0] nx,
   output logic [7:0] ny,
   output logic       wall_hit
);

   localparam logic [7:0] XMAX = 8'(GRID_W - 1);
   localparam logic [7:0] YMAX = 8'(GRID_H - 1);

   always_comb begin
      nx       = x;
      ny       = y;
      wall_hit = 1'b0;
      unique case (dir)
         DIR_UP: begin
            if (y == 8'd0) begin
`ifdef SNAKE_WRAP_WALLS_EN
               ny = YMAX;
`else
               wall_hit = 1'b1;
`endif
            end else begin
               ny = y - 8'd1;
            end
         end
         DIR_DOWN: begin
            if (y == YMAX) begin
`ifdef SNAKE_WRAP_WALLS_EN
               ny = 8'd0;
`else
               wall_hit = 1'b1;
`endif
            end else begin
               ny = y + 8'd1;
            end
         end
         DIR_LEFT: begin
            if (x == 8'd0) begin
`ifdef SNAKE_WRAP_WALLS_EN
               nx = XMAX;
`else
               wall_hit = 1'b1;
`endif
            end else begin
               nx = x - 8'd1;
            end
         end
         DIR_RIGHT: begin
            if (x == XMAX) begin
`ifdef SNAKE_WRAP_WALLS_EN
               nx = 8'd0;
`else
               wall_hit = 1'b1;
`endif
            end else begin
               nx = x + 8'd1;
            end
         end
      endcase
   end

endmodule

// File: rtl/snake_head_ctrl.sv
// Snake head controller: steps the head per tick, detects wall/self/food.
// Ports: clk, resetn, tick, start, btn_*, food_idx, occupied in;
// head_idx, head_we, len, food_hit, game_over out. Macro: SNAKE_WRAP_WALLS_EN.
module snake_head_ctrl
   import snake_pkg::*;
#(
   parameter int GRID_W   = GRID_W_DEF,
   parameter int GRID_H   = GRID_H_DEF,
   parameter int LEN_INIT = 3,
   parameter int LEN_MAX  = 200
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     tick,
   input  logic                     start,
   input  logic                     btn_up,
   input  logic                     btn_down,
   input  logic                     btn_left,
   input  logic                     btn_right,
   input  logic [7:0]               food_idx,
   input  logic [GRID_W*GRID_H-1:0] occupied,
   output logic [7:0]               head_idx,
   output logic                     head_we,
   output logic [7:0]               len,
   output logic                     food_hit,
   output logic                     game_over
);

   localparam logic [7:0] W8   = 8'(GRID_W);
   localparam logic [7:0] X0   = 8'd7;
   localparam logic [7:0] Y0   = 8'd7;
   localparam logic [7:0] LEN0 = 8'(LEN_INIT);
   localparam logic [7:0] LENM = 8'(LEN_MAX);

   state_t     state, state_d;
   dir_t       dir, dir_req;
   logic [7:0] x, y;
   logic [7:0] nx, ny;
   logic [7:0] nx_q, ny_q;
   logic       wall, wall_q;
   logic [7:0] cur_idx, next_idx;
   logic [7:0] len_inc;
   logic       dir_ok;
   logic       occ_hit;
   logic       food_match;

   snake_next_pos #(
      .GRID_W(GRID_W),
      .GRID_H(GRID_H)
   ) u_next (
      .x       (x),
      .y       (y),
      .dir     (dir),
      .nx      (nx),
      .ny      (ny),
      .wall_hit(wall)
   );

   assign cur_idx    = cell_idx(x, y, W8);
   assign next_idx   = cell_idx(nx_q, ny_q, W8);
   assign occ_hit    = occupied[next_idx];
   assign food_match = (next_idx == food_idx);
   assign len_inc    = (len >= LENM) ? LENM : len + 8'd1;

   // Highest-priority pressed button, then reject reversals.
   always_comb begin
      dir_req = dir;
      if (btn_up)         dir_req = DIR_UP;
      else if (btn_down)  dir_req = DIR_DOWN;
      else if (btn_left)  dir_req = DIR_LEFT;
      else if (btn_right) dir_req = DIR_RIGHT;
   end

   assign dir_ok = (btn_up | btn_down | btn_left | btn_right)
                 && (dir_req != dir_opposite(dir));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= S_IDLE;
      end else begin
         state <= state_d;
      end
   end

   always_comb begin
      state_d   = state;
      head_idx  = cur_idx;
      head_we   = 1'b0;
      food_hit  = 1'b0;
      game_over = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (start) state_d = S_SPAWN;
         end
         S_SPAWN: begin
            head_we = 1'b1;
            state_d = S_RUN;
         end
         S_RUN: begin
            if (tick) state_d = S_CHECK;
         end
         S_CHECK: begin
            if (wall_q) begin
               state_d = S_DEAD;
            end else if (occ_hit && !food_match) begin
               state_d = S_DEAD;
            end else begin
               state_d  = S_COMMIT;
               food_hit = food_match;
            end
         end
         S_COMMIT: begin
            // Present the new head in the strobe cycle itself.
            head_idx = next_idx;
            head_we  = 1'b1;
            state_d  = S_RUN;
         end
         S_DEAD: begin
            game_over = 1'b1;
            if (start) state_d = S_SPAWN;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         x      <= X0;
         y      <= Y0;
         dir    <= DIR_RIGHT;
         len    <= LEN0;
         nx_q   <= '0;
         ny_q   <= '0;
         wall_q <= 1'b0;
      end else begin
         if (state == S_RUN) begin
            if (dir_ok) dir <= dir_req;
            if (tick) begin
               nx_q   <= nx;
               ny_q   <= ny;
               wall_q <= wall;
            end
         end
         if (food_hit) len <= len_inc;
         if (state == S_COMMIT) begin
            x <= nx_q;
            y <= ny_q;
         end
         if (state == S_DEAD && start) begin
            x   <= X0;
            y   <= Y0;
            dir <= DIR_RIGHT;
            len <= LEN0;
         end
      end
   end

endmodule

// File: tb/tb_snake_head_ctrl.sv
// Scoreboard bench for snake_head_ctrl: stimulus queues expected strobes,
// a negedge monitor pops and compares them against head_we / food_hit.
module tb_snake_head_ctrl;
   import snake_pkg::*;

   logic         clk = 1'b0;
   logic         resetn = 1'b0;
   logic         tick = 1'b0;
   logic         start = 1'b0;
   logic         btn_up = 1'b0;
   logic         btn_down = 1'b0;
   logic         btn_left = 1'b0;
   logic         btn_right = 1'b0;
   logic [7:0]   food_idx = 8'd255;
   logic [224:0] occupied = '0;
   logic [7:0]   head_idx;
   logic         head_we;
   logic [7:0]   len;
   logic         food_hit;
   logic         game_over;

   snake_head_ctrl dut (
      .clk      (clk),
      .resetn   (resetn),
      .tick     (tick),
      .start    (start),
      .btn_up   (btn_up),
      .btn_down (btn_down),
      .btn_left (btn_left),
      .btn_right(btn_right),
      .food_idx (food_idx),
      .occupied (occupied),
      .head_idx (head_idx),
      .head_we  (head_we),
      .len      (len),
      .food_hit (food_hit),
      .game_over(game_over)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int idx;
      int due;
   } exp_t;

   exp_t we_q[$];
   int   food_q[$];
   int   checks = 0;
   int   failures = 0;

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d required %0d (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      int   f;
      if (head_we) begin
         if (we_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_head_we: got idx %0d cycle %0d required none",
                     head_idx, cyc);
         end else begin
            e = we_q.pop_front();
            chk("head_we_idx", int'(head_idx), e.idx);
            chk("head_we_cycle", cyc, e.due);
         end
      end
      if (we_q.size() > 0 && cyc > we_q[0].due) begin
         e = we_q.pop_front();
         checks++;
         failures++;
         $display("FAIL missing_head_we: got none required idx %0d at cycle %0d",
                  e.idx, e.due);
      end
      if (food_hit) begin
         if (food_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_food_hit: got pulse cycle %0d required none",
                     cyc);
         end else begin
            f = food_q.pop_front();
            chk("food_hit_cycle", cyc, f);
         end
      end
      if (food_q.size() > 0 && cyc > food_q[0]) begin
         f = food_q.pop_front();
         checks++;
         failures++;
         $display("FAIL missing_food_hit: got none required pulse at cycle %0d", f);
      end
   end

   task automatic cyc_wait(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic hw_reset();
      resetn = 1'b0;
      tick = 1'b0;
      start = 1'b0;
      {btn_up, btn_down, btn_left, btn_right} = 4'b0;
      cyc_wait(2);
      resetn = 1'b1;
      cyc_wait(1);
   endtask

   task automatic do_start(bit exp_spawn);
      start = 1'b1;
      if (exp_spawn) we_q.push_back('{112, cyc + 1});
      cyc_wait(1);
      start = 1'b0;
      cyc_wait(1);
   endtask

   task automatic do_tick(int exp_idx, bit exp_food);
      tick = 1'b1;
      if (exp_idx >= 0) we_q.push_back('{exp_idx, cyc + 2});
      if (exp_food) food_q.push_back(cyc + 1);
      cyc_wait(1);
      tick = 1'b0;
      cyc_wait(3);
   endtask

   task automatic press(bit u, bit d, bit l, bit r, int n);
      {btn_up, btn_down, btn_left, btn_right} = {u, d, l, r};
      cyc_wait(n);
      {btn_up, btn_down, btn_left, btn_right} = 4'b0;
   endtask

   int loop_pos[4] = '{113, 128, 127, 112};
   int exp_len;

   initial begin
      cyc_wait(1);
      hw_reset();
      chk("rst_head_idx", int'(head_idx), 112);
      chk("rst_head_we", int'(head_we), 0);
      chk("rst_len", int'(len), 3);
      chk("rst_food_hit", int'(food_hit), 0);
      chk("rst_game_over", int'(game_over), 0);

      do_start(1'b1);
      do_start(1'b0);
      for (int i = 0; i < 3; i++) do_tick(113 + i, 1'b0);
      chk("len_after_3", int'(len), 3);
      for (int i = 0; i < 4; i++) do_tick(116 + i, 1'b0);
`ifdef SNAKE_WRAP_WALLS_EN
      do_tick(105, 1'b0);
      chk("wrap_game_over", int'(game_over), 0);
`else
      do_tick(-1, 1'b0);
      chk("wall_game_over", int'(game_over), 1);
      chk("wall_head_idx", int'(head_idx), 119);
      do_tick(-1, 1'b0);
      chk("dead_stays", int'(game_over), 1);
`endif

      hw_reset();
      do_start(1'b1);
      press(1'b0, 1'b0, 1'b1, 1'b0, 3);
      do_tick(113, 1'b0);

      hw_reset();
      do_start(1'b1);
      press(1'b1, 1'b0, 1'b0, 1'b1, 3);
      do_tick(97, 1'b0);

      hw_reset();
      food_idx = 8'd113;
      do_start(1'b1);
      do_tick(113, 1'b1);
      chk("len_food", int'(len), 4);
      food_idx = 8'd114;
      occupied[114] = 1'b1;
      do_tick(114, 1'b1);
      chk("len_food_on_lit", int'(len), 5);
      occupied = '0;
      food_idx = 8'd255;
      occupied[115] = 1'b1;
      do_tick(-1, 1'b0);
      chk("self_game_over", int'(game_over), 1);
      chk("self_len", int'(len), 5);
      occupied = '0;
      do_start(1'b1);
      chk("restart_len", int'(len), 3);
      chk("restart_game_over", int'(game_over), 0);
      chk("restart_head_idx", int'(head_idx), 112);
      do_tick(113, 1'b0);

      tick = 1'b1;
      cyc_wait(1);
      tick = 1'b0;
      resetn = 1'b0;
      cyc_wait(1);
      resetn = 1'b1;
      cyc_wait(3);
      chk("midrst_head_idx", int'(head_idx), 112);
      chk("midrst_game_over", int'(game_over), 0);
      chk("midrst_len", int'(len), 3);
      do_tick(-1, 1'b0);
      do_start(1'b1);
      do_tick(113, 1'b0);

      hw_reset();
      do_start(1'b1);
      for (int i = 0; i < 198; i++) begin
         unique case (i % 4)
            0: press(1'b0, 1'b0, 1'b0, 1'b1, 2);
            1: press(1'b0, 1'b1, 1'b0, 1'b0, 2);
            2: press(1'b0, 1'b0, 1'b1, 1'b0, 2);
            default: press(1'b1, 1'b0, 1'b0, 1'b0, 2);
         endcase
         food_idx = 8'(loop_pos[i % 4]);
         do_tick(loop_pos[i % 4], 1'b1);
         exp_len = (4 + i > 200) ? 200 : 4 + i;
         chk("len_grow", int'(len), exp_len);
      end
      chk("len_saturated", int'(len), 200);
      food_idx = 8'd255;

      cyc_wait(4);
      chk("we_queue_drained", we_q.size(), 0);
      chk("food_queue_drained", food_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
